// File: rtl/ring_scan_pkg.sv
// Shared types and helpers for the ring scan scheduler.
// Pure declarations: no timing, no flow control.
// Not applicable: no backpressure.
package ring_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEF_N_CHANNELS = 3;

    // Index of the lowest set bit; 0 for an all-zero input.
    function automatic int onehot_to_index(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_scan_scheduler_if.sv
// Configuration and select bundle between channel control and the mux select consumers.
// Wires only: no latency. RING_SCAN_LOCK_EN adds lock / lock_channel.
// No backpressure: consumers must accept the select every cycle.
interface ring_scan_if #(
    parameter int N_CHANNELS = 3
);
    localparam int IW = $clog2(N_CHANNELS);

    logic [N_CHANNELS-1:0] channel_en;
    logic                  hold;
    logic [N_CHANNELS-1:0] ring_counter;
    logic [IW-1:0]         slot_index;
    logic                  slot_start;
    logic                  scanning;
`ifdef RING_SCAN_LOCK_EN
    logic                  lock;
    logic [IW-1:0]         lock_channel;

    modport master (output channel_en, hold, lock, lock_channel,
                    input  ring_counter, slot_index, slot_start, scanning);
    modport slave  (input  channel_en, hold, lock, lock_channel,
                    output ring_counter, slot_index, slot_start, scanning);
`else
    modport master (output channel_en, hold,
                    input  ring_counter, slot_index, slot_start, scanning);
    modport slave  (input  channel_en, hold,
                    output ring_counter, slot_index, slot_start, scanning);
`endif
endinterface

// File: rtl/ring_scan_scheduler_next_picker.sv
// Picks the next enabled channel strictly above the current one-hot, wrapping to the lowest.
// Combinational, zero latency. No backpressure.
// Current all-zero yields the lowest enabled channel; only-current-enabled yields current.
module ring_next_picker
    import ring_scan_pkg::*;
#(
    parameter int N_CHANNELS = DEF_N_CHANNELS
) (
    input  logic [N_CHANNELS-1:0] channel_en,
    input  logic [N_CHANNELS-1:0] cur,
    output logic [N_CHANNELS-1:0] nxt
);
    always_comb begin
        int                    base;
        logic                  have_above;
        logic [N_CHANNELS-1:0] above;
        logic [N_CHANNELS-1:0] lowest;
        base       = (|cur) ? onehot_to_index(32'(cur)) : -1;
        have_above = 1'b0;
        above      = '0;
        lowest     = '0;
        // Descending scan so the last hit is the lowest qualifying channel.
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (channel_en[i] && (i > base)) begin
                above      = '0;
                above[i]   = 1'b1;
                have_above = 1'b1;
            end
            if (channel_en[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
        nxt = have_above ? above : lowest;
    end
endmodule

// File: rtl/ring_scan_scheduler.sv
// Round-robin one-hot select sequencer: each enabled channel dwells DWELL_CYCLES clocks.
// All outputs registered, one clock from inputs. No backpressure; hold freezes the rotation.
// Optional RING_SCAN_LOCK_EN pins the select to lock_channel while lock is high.
module ring_scan_scheduler
    import ring_scan_pkg::*;
#(
    parameter int N_CHANNELS   = DEF_N_CHANNELS,
    parameter int DWELL_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    ring_scan_if.slave  sif
);
    localparam int IW = $clog2(N_CHANNELS);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_CHANNELS-1:0] ring_q, ring_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  start_q, start_d;

    logic [N_CHANNELS-1:0] pick;
    logic [N_CHANNELS-1:0] lock_oh;
    logic                  lock_ok;
    logic                  cur_en;

    ring_next_picker #(.N_CHANNELS(N_CHANNELS)) u_picker (
        .channel_en (sif.channel_en),
        .cur        (ring_q),
        .nxt        (pick)
    );

`ifdef RING_SCAN_LOCK_EN
    always_comb begin
        lock_oh = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (sif.lock_channel == IW'(i)) begin
                lock_oh[i] = 1'b1;
            end
        end
        // Out-of-range or disabled lock targets are ignored.
        lock_ok = sif.lock && |(lock_oh & sif.channel_en);
    end
`else
    assign lock_oh = '0;
    assign lock_ok = 1'b0;
`endif

    assign cur_en = |(ring_q & sif.channel_en);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ring_d  = ring_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lock_ok) begin
                    state_d = SCAN;
                    ring_d  = lock_oh;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end else if (|sif.channel_en && !sif.hold) begin
                    state_d = SCAN;
                    ring_d  = pick;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            SCAN: begin
                if (~|sif.channel_en) begin
                    state_d = IDLE;
                    ring_d  = '0;
                    cnt_d   = '0;
                end else if (!cur_en) begin
                    // A dropped channel is left immediately, even under hold or lock.
                    ring_d  = pick;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end else if (lock_ok) begin
                    ring_d  = lock_oh;
                    cnt_d   = '0;
                    start_d = (lock_oh != ring_q);
                end else if (sif.hold) begin
                    cnt_d   = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    ring_d  = pick;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ring_d  = '0;
                cnt_d   = '0;
            end
        endcase
        idx_d = IW'(onehot_to_index(32'(ring_d)));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ring_q  <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ring_q  <= ring_d;
            idx_q   <= idx_d;
            start_q <= start_d;
        end
    end

    assign sif.ring_counter = ring_q;
    assign sif.slot_index   = idx_q;
    assign sif.slot_start   = start_q;
    assign sif.scanning     = (state_q == SCAN);

endmodule

// File: tb/tb_ring_scan_scheduler.sv
// Scoreboarded bench: driver pushes model predictions, monitor pops and compares each cycle.
module tb_ring_scan_scheduler;
    localparam int N  = 3;
    localparam int DW = 4;
`ifdef RING_SCAN_LOCK_EN
    localparam bit HAS_LOCK = 1'b1;
`else
    localparam bit HAS_LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] ring;
        logic [1:0]   idx;
        logic         start;
        logic         scan;
    } obs_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ring_scan_if #(.N_CHANNELS(N)) sif ();

    ring_scan_scheduler #(.N_CHANNELS(N), .DWELL_CYCLES(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sif     (sif.slave)
    );

    always #5 clock = ~clock;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: selected channel index (-1 when idle) and clocks spent in the slot.
    int   m_sel   = -1;
    int   m_age   = 0;
    logic m_start = 1'b0;

    function automatic int next_en(input int from, input logic [N-1:0] en);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (from + k + N) % N;
            if (en[j]) return j;
        end
        return from;
    endfunction

    task automatic model(input logic rn, input logic [N-1:0] en, input logic h,
                         input logic lk, input int lc);
        logic lock_ok;
        lock_ok = HAS_LOCK && lk && (lc < N) && en[lc];
        m_start = 1'b0;
        if (!rn) begin
            m_sel = -1; m_age = 0;
        end else if (m_sel < 0) begin
            if (lock_ok) begin
                m_sel = lc; m_age = 0; m_start = 1'b1;
            end else if (en != 0 && !h) begin
                m_sel = next_en(-1, en); m_age = 0; m_start = 1'b1;
            end
        end else if (en == 0) begin
            m_sel = -1; m_age = 0;
        end else if (!en[m_sel]) begin
            m_sel = next_en(m_sel, en); m_age = 0; m_start = 1'b1;
        end else if (lock_ok) begin
            m_start = (lc != m_sel); m_sel = lc; m_age = 0;
        end else if (h) begin
            m_age = m_age;
        end else if (m_age == DW - 1) begin
            m_sel = next_en(m_sel, en); m_age = 0; m_start = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input logic rn, input logic [N-1:0] en, input logic h,
                        input logic lk = 1'b0, input int lc = 0);
        obs_t e;
        @(negedge clock);
        reset_n        = rn;
        sif.channel_en = en;
        sif.hold       = h;
`ifdef RING_SCAN_LOCK_EN
        sif.lock         = lk;
        sif.lock_channel = 2'(lc);
`endif
        model(rn, en, h, lk, lc);
        e.ring = '0;
        if (m_sel >= 0) e.ring[m_sel] = 1'b1;
        e.idx   = (m_sel >= 0) ? 2'(m_sel) : 2'd0;
        e.start = m_start;
        e.scan  = (m_sel >= 0);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sif.ring_counter, sif.slot_index, sif.slot_start, sif.scanning};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL select_cycle t=%0t got ring=%b idx=%0d start=%b scan=%b expected ring=%b idx=%0d start=%b scan=%b",
                             $time, a.ring, a.idx, a.start, a.scan, e.ring, e.idx, e.start, e.scan);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        logic [N-1:0] en;
        logic h, lk, rn;
        int lc;
        sif.channel_en = '0;
        sif.hold       = 1'b0;
`ifdef RING_SCAN_LOCK_EN
        sif.lock         = 1'b0;
        sif.lock_channel = '0;
`endif
        // Reset with everything enabled, then free run.
        repeat (2) step(1'b0, 3'b111, 1'b0);
        repeat (14) step(1'b1, 3'b111, 1'b0);
        // Channel 1 disabled: rotation skips it.
        repeat (12) step(1'b1, 3'b101, 1'b0);
        // Drop channel 1 while it is selected.
        guard = 0;
        while (m_sel != 1 && guard < 16) begin
            step(1'b1, 3'b111, 1'b0);
            guard++;
        end
        checks++;
        if (m_sel != 1) begin
            errors++;
            $display("FAIL reach_slot1 got sel=%0d expected sel=1 within 16 cycles", m_sel);
        end
        repeat (6) step(1'b1, 3'b101, 1'b0);
        // Hold mid-slot stretches it, then disable everything under hold.
        repeat (2) step(1'b1, 3'b111, 1'b0);
        repeat (3) step(1'b1, 3'b111, 1'b1);
        repeat (6) step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b1);
        repeat (2) step(1'b1, 3'b000, 1'b1);
        repeat (3) step(1'b1, 3'b010, 1'b1);
        repeat (3) step(1'b1, 3'b010, 1'b0);
`ifdef RING_SCAN_LOCK_EN
        guard = 0;
        while (!(m_sel == 0 && m_age == 0) && guard < 20) begin
            step(1'b1, 3'b111, 1'b0);
            guard++;
        end
        repeat (10) step(1'b1, 3'b111, 1'b0, 1'b1, 2);
        repeat (8)  step(1'b1, 3'b111, 1'b0);
        repeat (3)  step(1'b1, 3'b000, 1'b0);
        repeat (4)  step(1'b1, 3'b011, 1'b1, 1'b1, 1);
`endif
        // Randomised traffic.
        en = 3'b111; h = 1'b0; lk = 1'b0; lc = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 15) en = 3'($urandom_range(0, 7));
            h  = ($urandom_range(0, 99) < 12);
            rn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 8) begin
                lk = ~lk;
                lc = $urandom_range(0, 3);
            end
            step(rn, en, h, lk, lc);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
